// File: rtl/mux_pkg.sv
// Shared helpers and default geometry for the mux family.
// Index-width and onehot decode helpers live here.
package mux_pkg;

  localparam int MUX_WIDTH = 8;
  localparam int MUX_N     = 4;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // OR-reduce decode: valid only for a onehot or zero input
  function automatic logic [4:0] oh_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = idx | 5'(i);
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_nto1_arb.sv
// Combinational round-robin arbiter.
// Rotates requests past the last grant, picks lowest, rotates back.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = MUX_N,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [N-1:0] rot;
  logic [N-1:0] oh;
  int           start;
  int           pos;

  always_comb begin
    start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
    rot = '0;
    for (int i = 0; i < N; i++)
      rot[i] = req[(i + start) % N];
    oh = rot & (~rot + N'(1));
    pos = int'(oh_to_idx(32'(oh))) + start;
    if (pos >= N) pos = pos - N;
    gnt_vld = |req;
    gnt_idx = SEL_W'(pos);
  end

endmodule

// File: rtl/mux_rr_nto1.sv
// N-to-1 registered mux with valid/ready per channel.
// Round-robin or fixed (sel_i) steering into one output register.
module mux_rr_nto1
  import mux_pkg::*;
#(
  parameter  int WIDTH = MUX_WIDTH,
  parameter  int N     = MUX_N,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fixed_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] last;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             load;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .last    (last),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    load = !out_valid || out_ready;
    if (fixed_i) begin
      gnt_vld = int'(sel_i) < N;
      gnt_idx = sel_i;
    end else begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end
    in_ready = '0;
    if (rst_n && load && gnt_vld)
      in_ready[gnt_idx] = 1'b1;
    xfer = |(in_valid & in_ready);
  end

  // Fixed mode must not disturb the rr pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SEL_W'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel   <= gnt_idx;
      if (!fixed_i) last <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed bench for mux_rr_nto1 (N=4, WIDTH=8).
// Expected beats are queued by stimulus, checked by a monitor.
module tb_mux_rr_nto1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fixed_i;
  logic [1:0]  sel_i;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  mux_rr_nto1 #(.WIDTH(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fixed_i   (fixed_i),
    .sel_i     (sel_i),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch);
    logic [1:0] s;
    s = 2'(ch);
    exp_q.push_back({s, 8'h10 + 8'(ch)});
  endtask

  // Monitor: output transfer happens at the next posedge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat unexpected got %0h/%0d",
                 out_data, out_sel);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("beat", {22'd0, out_sel, out_data}, {22'd0, e});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    fixed_i   = 1'b0;
    sel_i     = 2'd0;
    in_data   = 32'h13121110;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready", 32'(in_ready), 32'(1 << (i % 4)));
      push(i % 4);
      tick();
      chk("rr_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 4'b0000;
    tick();
    chk("drain", 32'(out_valid), 32'h0);

    // last=0 -> ch2 alone makes last=2
    in_valid = 4'b0100;
    #1;
    chk("sp_ch2", 32'(in_ready), 32'b0100);
    push(2);
    tick();
    in_valid = 4'b0010;
    #1;
    chk("sp_ch1", 32'(in_ready), 32'b0010);
    push(1);
    tick();
    in_valid = 4'b1001;
    #1;
    chk("wrap_ch3", 32'(in_ready), 32'b1000);
    push(3);
    tick();
    #1;
    chk("wrap_ch0", 32'(in_ready), 32'b0001);
    push(0);
    tick();
    in_valid = 4'b0000;
    tick();
    tick();

    // Backpressure, last=0
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    chk("bp_first", 32'(in_ready), 32'b0010);
    push(1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_data", 32'(out_data), 32'h11);
      chk("bp_sel", 32'(out_sel), 32'd1);
      chk("bp_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_repl_rdy", 32'(in_ready), 32'b0100);
    push(2);
    tick();
    chk("bp_repl_data", 32'(out_data), 32'h12);
    chk("bp_repl_vld", 32'(out_valid), 32'h1);
    in_valid = 4'b0000;
    tick();
    tick();

    // Fixed mode, last stays 2
    fixed_i  = 1'b1;
    sel_i    = 2'd2;
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fx_ready", 32'(in_ready), 32'b0100);
      push(2);
      tick();
      chk("fx_data", 32'(out_data), 32'h12);
    end
    out_ready = 1'b0;
    sel_i     = 2'd3;
    #1;
    chk("fx_hold_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("fx_hold_data", 32'(out_data), 32'h12);
    chk("fx_hold_sel", 32'(out_sel), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("fx_sel3_rdy", 32'(in_ready), 32'b1000);
    push(3);
    tick();
    chk("fx_sel3_sel", 32'(out_sel), 32'd3);
    in_valid = 4'b0000;
    sel_i    = 2'd1;
    #1;
    chk("fx_novalid", 32'(in_ready), 32'b0010);
    tick();
    tick();

    fixed_i  = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk("fx_kept_last", 32'(in_ready), 32'b1000);
    push(3);
    tick();
    in_valid = 4'b0000;
    tick();
    tick();

    // Reset with a held beat; beat never leaves
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    tick();
    chk("mr_held", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_ready", 32'(in_ready), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mr_restart", 32'(in_ready), 32'b0001);
    push(0);
    tick();
    in_valid = 4'b0000;
    tick();
    tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
